// File: rtl/match_event_fifo.sv
// Time-stamps qualified match_filter detections and queues them in a small
// first-word-fall-through FIFO, with holdoff suppression and drop accounting.
module match_event_fifo #(
  parameter int DEPTH    = 8,
  parameter int HOLDOFF  = 16,
  parameter int TS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rxstrobe,
  input  logic                     valid,
  input  logic                     match,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic [TS_WIDTH-1:0]      rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_count,
  output logic                     event_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [AW:0]   DEPTH_LVL = (AW + 1)'(DEPTH);

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [HW-1:0]       holdoff_q, holdoff_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic [7:0]          drop_q, drop_d;
  logic                pulse_q, pulse_d;
  logic [TS_WIDTH-1:0] mem_q [DEPTH];

  logic event_ok;
  logic pop;
  logic push;
  logic drop;
  logic wr_en;

  always_comb begin
    event_ok = valid & match & enable & (holdoff_q == '0);
    pop      = rd_en & ~empty_q;
    push     = event_ok & (~full_q | pop);
    drop     = event_ok & full_q & ~pop;

    ts_d      = ts_q + {{(TS_WIDTH-1){1'b0}}, rxstrobe};
    holdoff_d = holdoff_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    drop_d    = drop_q;
    pulse_d   = 1'b0;
    wr_en     = 1'b0;

    if (clear) begin
      // Flush wins over any same-cycle traffic; the timestamp keeps running.
      holdoff_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      drop_d    = '0;
    end else begin
      if (event_ok) begin
        holdoff_d = HOLD_LOAD;
      end else if (rxstrobe && (holdoff_q != '0)) begin
        holdoff_d = holdoff_q - 1'b1;
      end

      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end

      if (drop && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 1'b1;
      end

      pulse_d = event_ok;
    end

    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH_LVL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q      <= '0;
      holdoff_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      drop_q    <= '0;
      pulse_q   <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      holdoff_q <= holdoff_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
      pulse_q   <= pulse_d;
    end
  end

  // Storage is left unreset; the head is don't-care whenever empty is high.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!reset && wr_en && (wr_ptr_q == AW'(gi))) begin
        mem_q[gi] <= ts_q;
      end
    end
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign empty       = empty_q;
  assign full        = full_q;
  assign level       = level_q;
  assign drop_count  = drop_q;
  assign event_pulse = pulse_q;

endmodule

// File: tb/tb_match_event_fifo.sv
// Bench for match_event_fifo: directed scenarios plus random traffic against a
// queue-based reference, run on a HOLDOFF=16/32-bit build and a HOLDOFF=0/8-bit build.
module tb_match_event_fifo;

  logic clk = 1'b0;
  logic reset = 1'b0, rxstrobe = 1'b0, valid = 1'b0, match = 1'b0;
  logic enable = 1'b1, clear = 1'b0, rd_en = 1'b0;

  logic [31:0] rd0;
  logic [7:0]  rd1;
  logic        em0, em1, fu0, fu1, ep0, ep1;
  logic [3:0]  lv0, lv1;
  logic [7:0]  dr0, dr1;

  int checks = 0;
  int errors = 0;

  match_event_fifo #(.DEPTH(8), .HOLDOFF(16), .TS_WIDTH(32)) dut0 (
    .clk(clk), .reset(reset), .rxstrobe(rxstrobe), .valid(valid), .match(match),
    .enable(enable), .clear(clear), .rd_en(rd_en), .rd_data(rd0), .empty(em0),
    .full(fu0), .level(lv0), .drop_count(dr0), .event_pulse(ep0));

  match_event_fifo #(.DEPTH(8), .HOLDOFF(0), .TS_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .rxstrobe(rxstrobe), .valid(valid), .match(match),
    .enable(enable), .clear(clear), .rd_en(rd_en), .rd_data(rd1), .empty(em1),
    .full(fu1), .level(lv1), .drop_count(dr1), .event_pulse(ep1));

  always #5 clk = ~clk;

  // Reference state, one slot per build.
  longint ts_m [2];
  int     ho_m [2];
  int     drop_m [2];
  bit     ep_m [2];
  longint q0 [$];
  longint q1 [$];
  int     hold_p [2] = '{16, 0};
  longint mask_p [2] = '{64'hFFFF_FFFF, 64'hFF};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    longint q[$];
    bit ev, popok;
    int sz;
    if (i == 0) q = q0; else q = q1;
    if (reset) begin
      ts_m[i] = 0; q.delete(); drop_m[i] = 0; ho_m[i] = 0; ep_m[i] = 0;
    end else begin
      ev = valid && match && enable && (ho_m[i] == 0);
      if (clear) begin
        q.delete(); drop_m[i] = 0; ho_m[i] = 0; ep_m[i] = 0;
      end else begin
        sz = q.size();
        popok = rd_en && (sz > 0);
        if (popok) void'(q.pop_front());
        if (ev) begin
          if (sz < 8 || popok) q.push_back(ts_m[i]);
          else if (drop_m[i] < 255) drop_m[i]++;
        end
        if (ev) ho_m[i] = hold_p[i];
        else if (rxstrobe && ho_m[i] > 0) ho_m[i]--;
        ep_m[i] = ev;
      end
      ts_m[i] = (ts_m[i] + longint'(rxstrobe)) & mask_p[i];
    end
    if (i == 0) q0 = q; else q1 = q;
  endtask

  task automatic compare_all();
    chk("lvl0", 64'(lv0), 64'(q0.size()));
    chk("empty0", 64'(em0), 64'(q0.size() == 0));
    chk("full0", 64'(fu0), 64'(q0.size() == 8));
    chk("drop0", 64'(dr0), 64'(drop_m[0]));
    chk("pulse0", 64'(ep0), 64'(ep_m[0]));
    if (q0.size() > 0) chk("rd0", 64'(rd0), q0[0]);
    chk("lvl1", 64'(lv1), 64'(q1.size()));
    chk("empty1", 64'(em1), 64'(q1.size() == 0));
    chk("full1", 64'(fu1), 64'(q1.size() == 8));
    chk("drop1", 64'(dr1), 64'(drop_m[1]));
    chk("pulse1", 64'(ep1), 64'(ep_m[1]));
    if (q1.size() > 0) chk("rd1", 64'(rd1), q1[0]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic strobes(input int n, input int rate);
    for (int k = 0; k < n; k++) begin
      rxstrobe = 1'b0;
      for (int r = 0; r < rate - 1; r++) cycle();
      rxstrobe = 1'b1;
      cycle();
    end
    rxstrobe = 1'b0;
  endtask

  task automatic fire();
    valid = 1'b1; match = 1'b1;
    cycle();
    valid = 1'b0; match = 1'b0;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_lvl", 64'(lv0), 0);
    chk("rst_empty", 64'(em0), 1);
    chk("rst_full", 64'(fu0), 0);
    chk("rst_drop", 64'(dr0), 0);

    // First event after 100 strobes at rate 16.
    strobes(100, 16);
    fire();
    chk("s1_pulse", 64'(ep0), 1);
    chk("s1_rd", 64'(rd0), 100);
    chk("s1_lvl", 64'(lv0), 1);
    chk("s1_empty", 64'(em0), 0);

    // Holdoff suppresses the match at count 20.
    do_reset();
    strobes(10, 1); fire();
    strobes(10, 1); fire();
    strobes(10, 1); fire();
    chk("s2_lvl", 64'(lv0), 2);
    chk("s2_rd_a", 64'(rd0), 10);
    pop1();
    chk("s2_rd_b", 64'(rd0), 30);
    pop1();
    chk("s2_empty", 64'(em0), 1);

    // Fill past capacity, then event+pop while full.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      strobes(17, 1); fire();
    end
    chk("s3_full", 64'(fu0), 1);
    chk("s3_lvl", 64'(lv0), 8);
    chk("s3_drop", 64'(dr0), 1);
    strobes(17, 1);
    chk("s4_head", 64'(rd0), 17);
    valid = 1'b1; match = 1'b1; rd_en = 1'b1;
    cycle();
    valid = 1'b0; match = 1'b0; rd_en = 1'b0;
    chk("s4_drop", 64'(dr0), 1);
    chk("s4_lvl", 64'(lv0), 8);
    for (int k = 0; k < 8; k++) begin
      chk("s4_drain", 64'(rd0), (k < 7) ? 64'(34 + 17 * k) : 64'd170);
      pop1();
    end
    chk("s4_empty", 64'(em0), 1);

    // Unqualified matches, then clear with occupancy and drops.
    do_reset();
    valid = 1'b0; match = 1'b1;
    cycle();
    chk("s5_novalid_pulse", 64'(ep0), 0);
    valid = 1'b1; enable = 1'b0;
    cycle();
    chk("s5_noen_pulse", 64'(ep0), 0);
    chk("s5_noen_lvl", 64'(lv0), 0);
    valid = 1'b0; match = 1'b0; enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      strobes(17, 1); fire();
    end
    for (int k = 0; k < 5; k++) pop1();
    chk("s5_lvl3", 64'(lv0), 3);
    chk("s5_drop2", 64'(dr0), 2);
    valid = 1'b1; match = 1'b1; clear = 1'b1;
    cycle();
    valid = 1'b0; match = 1'b0; clear = 1'b0;
    chk("s5_clr_lvl", 64'(lv0), 0);
    chk("s5_clr_empty", 64'(em0), 1);
    chk("s5_clr_drop", 64'(dr0), 0);
    chk("s5_clr_pulse", 64'(ep0), 0);
    fire();
    chk("s5_ts_kept", 64'(rd0), 170);

    // Wrap on the 8-bit build, then reset mid-drain.
    do_reset();
    strobes(255, 1);
    fire();
    strobes(1, 1);
    fire();
    chk("s6_rd_255", 64'(rd1), 255);
    pop1();
    chk("s6_rd_0", 64'(rd1), 0);
    fire(); fire();
    valid = 1'b1; match = 1'b1; rd_en = 1'b1; reset = 1'b1;
    cycle();
    valid = 1'b0; match = 1'b0; rd_en = 1'b0; reset = 1'b0;
    chk("s6_rst_lvl", 64'(lv1), 0);
    chk("s6_rst_empty", 64'(em1), 1);
    chk("s6_rst_full", 64'(fu1), 0);
    chk("s6_rst_drop", 64'(dr1), 0);
    chk("s6_rst_pulse", 64'(ep1), 0);

    // Random traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(499) == 0);
      clear    = ($urandom_range(63) == 0);
      rxstrobe = ($urandom_range(1) == 0);
      valid    = ($urandom_range(3) != 0);
      match    = ($urandom_range(1) == 0);
      enable   = ($urandom_range(7) != 0);
      rd_en    = ($urandom_range(2) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_event_fifo.md
Name: match_event_fifo

Overview:
- Downstream consumer of match_filter's valid/match outputs in the RX inband path.
- Keeps a free-running timestamp counter in rxstrobe (sample) units.
- Each accepted match event is time-stamped and queued in a small FIFO.
- The FIFO is drained by the inband status/packet builder, with duplicate-match suppression and drop accounting.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- HOLDOFF, 16, number of rxstrobe samples after an accepted event during which further matches are suppressed; 0 disables holdoff.
- TS_WIDTH, 32, timestamp counter and FIFO data width.

Ports:
- clk  in  1  system clock, shared with match_filter.
- reset  in  1  synchronous active-high reset.
- rxstrobe  in  1  sample strobe, same signal that drives match_filter.
- valid  in  1  match_filter output-valid qualifier.
- match  in  1  match_filter detection flag; qualified only when valid=1.
- enable  in  1  capture enable; the timestamp counter runs regardless.
- clear  in  1  synchronous flush of FIFO, holdoff and drop counter.
- rd_en  in  1  pop request from consumer.
- rd_data  out  TS_WIDTH  head-of-FIFO timestamp (first-word-fall-through).
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- drop_count  out  8  events lost to a full FIFO; saturates at 255.
- event_pulse  out  1  one-cycle registered flag, high the cycle after an event is accepted (queued or dropped).

Behaviour:
- Reset (reset=1 at a clk edge): ts counter=0, FIFO pointers/level=0, empty=1, full=0, drop_count=0, holdoff=0, event_pulse=0.
- rd_data after reset is don't-care while empty=1.
- Reset overrides every other input, including mid-transfer; all in-flight state is discarded.
- Timestamp counter:
  - Increments by 1 on every clk cycle with rxstrobe=1.
  - Wraps from 2^TS_WIDTH-1 to 0.
  - Unaffected by clear and enable.
- Event condition, evaluated each cycle: valid & match & enable & (holdoff==0).
  - The stored value is the counter value before that cycle's increment.
  - With rxstrobe=1 on the event cycle, the stored value is the count prior to the increment.
- Holdoff:
  - On an event, holdoff loads HOLDOFF.
  - Otherwise it decrements by 1 on each rxstrobe cycle while nonzero.
  - HOLDOFF=0 means every qualified match is an event.
- Push:
  - On an event with full=0, or with full=1 and a pop in the same cycle, write the timestamp at the write pointer.
  - The write pointer advances modulo DEPTH.
- Drop: on an event with full=1 and no pop, the entry is not written and drop_count increments, saturating at 255. Holdoff still loads and event_pulse still fires.
- Pop:
  - rd_en=1 with empty=0 advances the read pointer.
  - rd_data always reflects the entry at the read pointer.
  - rd_en while empty is ignored with no state change.
- Simultaneous push and pop: level is unchanged; legal at both full and empty.
  - At empty, the pop is ignored and the push lands, so level becomes 1.
- level/empty/full are registered and update the cycle after the push/pop edge. rd_data of a newly pushed entry is valid the cycle after the push.
- clear:
  - Empties the FIFO (pointers=0, level=0), zeroes drop_count and holdoff.
  - Has priority over a same-cycle push/pop; the event in that cycle is discarded with no event_pulse.
  - Timestamp counter continues.
- event_pulse is the registered event condition, latency 1 clk; it is never high two consecutive cycles unless HOLDOFF=0.

Test Plan:
- Reset, then 100 rxstrobe pulses (rate 16), then valid=match=1 for 1 cycle with enable=1 → event_pulse 1 cycle later; rd_data=100, level=1, empty=0.
- HOLDOFF=16: matches at strobe counts 10, 20, 30 → only 10 and 30 queued (20 suppressed); drain with rd_en → rd_data 10 then 30, then empty=1.
- Fill: 9 events spaced by >HOLDOFF strobes with DEPTH=8, no reads → full=1, level=8, drop_count=1; drain yields the first 8 timestamps in order.
- Full FIFO plus event and rd_en in the same cycle → drop_count unchanged, level stays 8; the new timestamp becomes the last entry read out.
- match=1 with valid=0, or with enable=0 → no event_pulse, level stays 0. Then clear while level=3 and drop_count=2 → level=0, empty=1, drop_count=0; counter value unchanged.
- Counter preset near wrap (TS_WIDTH=8 build): event at count 255, next strobe, event at count 0 → rd_data 255 then 0. Reset asserted mid-drain → all outputs at reset values on the next cycle.
